// File: rtl/vdma_wr_axi_bridge.sv
// VDMA write-request responder: buffers each granted burst in a beat FIFO and
// issues it as one AXI4 INCR write. Optional B-channel timeout: VDMA_WR_BRIDGE_TIMEOUT_EN.
module vdma_wr_axi_bridge #(
  parameter int unsigned g_DW      = 64,
  parameter int unsigned g_AW      = 38,
  parameter int unsigned g_FIFO_AW = 8,
  parameter int unsigned g_TIMEOUT = 4096
) (
  input  logic              ddr_clk_i,
  input  logic              ddr_clk_rst_i,
  input  logic              write_req_i,
  input  logic [g_AW-1:0]   write_start_addr_i,
  input  logic [7:0]        write_length_i,
  input  logic [g_DW-1:0]   data_i,
  input  logic              data_valid_i,
  output logic              write_ackn_o,
  output logic              write_done_o,
  output logic [g_AW-1:0]   awaddr_o,
  output logic [7:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [g_DW-1:0]   wdata_o,
  output logic [g_DW/8-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic              err_clr_i,
  output logic              err_overflow_o,
  output logic              err_resp_o,
  output logic              timeout_err_o
);

  localparam int unsigned DEPTH = 1 << g_FIFO_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [g_AW-1:0]       addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            bcnt_q, bcnt_d;
  logic [8:0]            rcnt_q, rcnt_d;
  logic [g_FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [g_FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [g_FIFO_AW:0]    cnt_q, cnt_d;
  logic [g_DW-1:0]       mem_q [DEPTH];
  logic                  ackn_q, ackn_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  resp_q, resp_d;
  logic                  resp_set;

  logic fifo_empty, push, pop, stray, wvalid, wlast;

`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(g_TIMEOUT) + 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;
  logic          late_q, late_d;
`endif

  // Beats are only accepted while rcnt_q counts down the remaining beats of
  // the granted burst; it loads during the ackn cycle, so the window opens one later.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    push       = data_valid_i && (rcnt_q != '0);
    stray      = data_valid_i && (rcnt_q == '0);
    wvalid     = (state_q == ST_DATA) && !fifo_empty;
    wlast      = wvalid && (bcnt_q == len_q);
    pop        = wvalid && wready_i;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    ackn_d   = 1'b0;
    done_d   = 1'b0;
    resp_set = 1'b0;
`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    tout_d   = tout_q;
    late_d   = late_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
        if (late_q && bvalid_i) late_d = 1'b0;
`endif
        if (write_req_i && fifo_empty) begin
          addr_d  = write_start_addr_i;
          len_d   = write_length_i;
          bcnt_d  = '0;
          ackn_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (awready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (pop) begin
          bcnt_d = bcnt_q + 8'd1;
          if (wlast) begin
            state_d = ST_RESP;
`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      ST_RESP: begin
        if (bvalid_i) begin
          done_d   = 1'b1;
          resp_set = (bresp_i != 2'b00);
          state_d  = ST_IDLE;
        end
`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
        else if (tcnt_q == TW'(g_TIMEOUT - 1)) begin
          done_d  = 1'b1;
          tout_d  = 1'b1;
          late_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (ackn_q)    rcnt_d = {1'b0, len_q} + 9'd1;
    else if (push) rcnt_d = rcnt_q - 9'd1;
    else           rcnt_d = rcnt_q;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    ovf_d  = err_clr_i ? 1'b0 : (ovf_q | stray);
    resp_d = err_clr_i ? 1'b0 : (resp_q | resp_set);
`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
    if (err_clr_i) tout_d = 1'b0;
`endif
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_clk_rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      bcnt_q   <= '0;
      rcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ackn_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      rcnt_q   <= rcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ackn_q   <= ackn_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      resp_q   <= resp_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge ddr_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
  always_ff @(posedge ddr_clk_i) begin
    if (ddr_clk_rst_i) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
      late_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
      late_q <= late_d;
    end
  end
  assign timeout_err_o = tout_q;
  assign bready_o      = (state_q == ST_RESP) || ((state_q == ST_IDLE) && late_q);
`else
  assign timeout_err_o = 1'b0;
  assign bready_o      = (state_q == ST_RESP);
`endif

  assign write_ackn_o   = ackn_q;
  assign write_done_o   = done_q;
  assign awaddr_o       = addr_q;
  assign awlen_o        = len_q;
  assign awsize_o       = 3'b011;
  assign awburst_o      = 2'b01;
  assign awvalid_o      = (state_q == ST_ADDR);
  assign wvalid_o       = wvalid;
  assign wlast_o        = wlast;
  assign wdata_o        = wvalid ? mem_q[rd_ptr_q] : '0;
  assign wstrb_o        = {(g_DW/8){wvalid}};
  assign err_overflow_o = ovf_q;
  assign err_resp_o     = resp_q;

endmodule

// File: tb/tb_vdma_wr_axi_bridge.sv
// Directed bench for vdma_wr_axi_bridge: drives VDMA bursts, plays AXI slave,
// and checks every AW/W/B observation against bench-computed expectations.
module tb_vdma_wr_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_req_i = 1'b0;
  logic [37:0] write_start_addr_i = '0;
  logic [7:0]  write_length_i = '0;
  logic [63:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        write_ackn_o, write_done_o;
  logic [37:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [63:0] wdata_o;
  logic [7:0]  wstrb_o;
  logic        wlast_o, wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = '0;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
  logic        err_clr_i = 1'b0;
  logic        err_overflow_o, err_resp_o, timeout_err_o;

  always #5 clk = ~clk;

  vdma_wr_axi_bridge #(.g_DW(64), .g_AW(38), .g_FIFO_AW(8), .g_TIMEOUT(16)) dut (
    .ddr_clk_i(clk), .ddr_clk_rst_i(rst),
    .write_req_i(write_req_i), .write_start_addr_i(write_start_addr_i),
    .write_length_i(write_length_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .write_ackn_o(write_ackn_o), .write_done_o(write_done_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .err_clr_i(err_clr_i), .err_overflow_o(err_overflow_o), .err_resp_o(err_resp_o),
    .timeout_err_o(timeout_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ovf  = 1'b0;
  logic exp_resp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_pat(input logic [37:0] addr, input int idx);
    return 64'hA500_0000_0000_0000 ^ ({26'd0, addr} << 16) ^ 64'(idx);
  endfunction

  task automatic reset_vals();
    chk("rst_ackn",    write_ackn_o, 0);
    chk("rst_done",    write_done_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_awaddr",  awaddr_o, 0);
    chk("rst_awlen",   awlen_o, 0);
    chk("rst_awsize",  awsize_o, 3'b011);
    chk("rst_awburst", awburst_o, 2'b01);
    chk("rst_wvalid",  wvalid_o, 0);
    chk("rst_wlast",   wlast_o, 0);
    chk("rst_wdata",   wdata_o, 0);
    chk("rst_wstrb",   wstrb_o, 0);
    chk("rst_bready",  bready_o, 0);
    chk("rst_ovf",     err_overflow_o, 0);
    chk("rst_resp",    err_resp_o, 0);
    chk("rst_tout",    timeout_err_o, 0);
  endtask

  // One burst end to end. Inputs change 1 time unit after posedge; outputs are
  // sampled on negedge, so a sample sees exactly the inputs the next edge uses.
  task automatic run_burst(input logic [37:0] addr, input logic [7:0] len, input int wmode,
                           input int aw_stall, input logic [1:0] bresp, input int rst_after,
                           input bit no_b);
    logic [63:0] exp_q[$];
    logic [63:0] prev_data, exp_d;
    int  sent = 0, wcnt = 0, acks = 0, aw_hs = 0, stalls = 0, dones = 0;
    int  b_k = -1, resp_k = -1, rst_k = -1;
    bit  ack_seen = 0, aw_seen = 0, prev_stall = 0, fin = 0;
    int  k = 0;

    @(posedge clk); #1;
    write_req_i = 1'b1; write_start_addr_i = addr; write_length_i = len;
    awready_i = 1'b0; wready_i = (wmode == 0); bvalid_i = 1'b0; bresp_i = bresp;
    data_valid_i = 1'b0;

    while (!fin && k < 3000) begin
      @(negedge clk);
      if (k == 1) chk("ack_latency", write_ackn_o, 1);
      if (write_ackn_o) begin acks++; ack_seen = 1; end
      if (wvalid_o) chk("w_after_aw", aw_seen, 1);
      if (awvalid_o) begin
        chk("awaddr", awaddr_o, addr);
        chk("awlen", awlen_o, len);
        if (awready_i) begin aw_seen = 1; aw_hs++; end
        else stalls++;
      end
      if (prev_stall) begin
        chk("w_hold_valid", wvalid_o, 1);
        chk("w_hold_data", wdata_o, prev_data);
      end
      prev_stall = wvalid_o && !wready_i;
      prev_data  = wdata_o;
      if (wvalid_o && wready_i) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("wdata", wdata_o, exp_d);
        chk("wlast", wlast_o, wcnt == int'(len));
        chk("wstrb", wstrb_o, 8'hFF);
        wcnt++;
      end
      if (bready_o && resp_k < 0) resp_k = k;
      if (bvalid_i && bready_o) b_k = k;
      if (write_done_o) begin
        dones++;
        if (no_b) chk("timeout_latency", k - resp_k, 16);
        else      chk("done_latency", k - b_k, 1);
        fin = 1;
      end
      if (rst_k >= 0 && k == rst_k + 1) begin
        reset_vals();
        fin = 1;
      end
      if (fin) break;

      @(posedge clk); #1;
      write_req_i  = !ack_seen;
      awready_i    = (k + 1 > aw_stall);
      wready_i     = (wmode == 0) ? 1'b1 : ((k + 1) % 3 == 0);
      bvalid_i     = !no_b && (resp_k >= 0) && (b_k < 0);
      data_valid_i = 1'b0;
      rst          = 1'b0;
      if (rst_after > 0 && rst_k < 0 && wcnt >= rst_after) begin
        rst = 1'b1;
        rst_k = k + 1;
      end else if (ack_seen && sent <= int'(len) && rst_k < 0) begin
        data_valid_i = 1'b1;
        data_i = beat_pat(addr, sent);
        exp_q.push_back(data_i);
        sent++;
      end
      k++;
    end

    chk("burst_finished", fin, 1);
    @(posedge clk); #1;
    rst = 1'b0; write_req_i = 1'b0; bvalid_i = 1'b0; data_valid_i = 1'b0;
    if (rst_after > 0) begin
      exp_ovf = 1'b0; exp_resp = 1'b0;
      return;
    end
    @(negedge clk);
    chk("done_pulse_len", write_done_o, 0);
    chk("ackn_count", acks, 1);
    chk("aw_hs_count", aw_hs, 1);
    chk("aw_stall_cycles", stalls, aw_stall);
    chk("beat_count", wcnt, int'(len) + 1);
    chk("fifo_drained", exp_q.size(), 0);
    chk("done_count", dones, 1);
    chk("err_overflow", err_overflow_o, exp_ovf);
    chk("err_resp", err_resp_o, exp_resp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_vals();
    @(posedge clk); #1 rst = 1'b0;

    run_burst(38'h1000, 8'd7, 0, 0, 2'b00, 0, 0);
    run_burst(38'h2_0000, 8'd255, 1, 0, 2'b00, 0, 0);
    run_burst(38'h3008, 8'd15, 0, 20, 2'b00, 0, 0);

    @(posedge clk); #1 data_valid_i = 1'b1; data_i = 64'h1;
    @(posedge clk); #1 data_valid_i = 1'b0;
    @(negedge clk);
    chk("stray_beat_ovf", err_overflow_o, 1);
    exp_ovf = 1'b1;

    exp_resp = 1'b1;
    run_burst(38'h4000, 8'd3, 0, 0, 2'b10, 0, 0);

    @(posedge clk); #1 err_clr_i = 1'b1; data_valid_i = 1'b1;
    @(posedge clk); #1 err_clr_i = 1'b0; data_valid_i = 1'b0;
    @(negedge clk);
    chk("clr_ovf", err_overflow_o, 0);
    chk("clr_resp", err_resp_o, 0);
    exp_ovf = 1'b0; exp_resp = 1'b0;

    run_burst(38'h5000, 8'd7, 0, 0, 2'b00, 3, 0);
    run_burst(38'h6000, 8'd0, 0, 0, 2'b00, 0, 0);

`ifdef VDMA_WR_BRIDGE_TIMEOUT_EN
    run_burst(38'h7000, 8'd1, 0, 0, 2'b00, 0, 1);
    chk("timeout_err_set", timeout_err_o, 1);
    chk("late_b_ready", bready_o, 1);
`else
    chk("timeout_err_tied", timeout_err_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
